// File: rtl/mac_vec_pipe.sv
// mac_vec_pipe: three-stage signed dot-product MAC with burst accumulation.
// Ports: clk/rst_n (sync, active-low), beat in (in_valid/first/last,
// half_mode, a_vec, b_vec, partial_sum_in), result out (out_valid,
// partial_sum_out, out_sat).
module mac_vec_pipe #(
    parameter int LANES  = 33,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic                    half_mode,
    input  logic [LANES*DATA_W-1:0] a_vec,
    input  logic [LANES*DATA_W-1:0] b_vec,
    input  logic [ACC_W-1:0]        partial_sum_in,
    output logic                    out_valid,
    output logic [ACC_W-1:0]        partial_sum_out,
    output logic                    out_sat
);
    localparam int HALF_W = DATA_W / 2;
    localparam int PROD_W = 2 * DATA_W;
    localparam int NPROD  = 2 * LANES;
    localparam int SUM_W  = PROD_W + $clog2(NPROD);
    localparam int RAW_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    function automatic logic [PROD_W-1:0] mul_full(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [PROD_W-1:0] ax;
        logic [PROD_W-1:0] bx;
        ax = {{DATA_W{a[DATA_W-1]}}, a};
        bx = {{DATA_W{b[DATA_W-1]}}, b};
        return ax * bx;
    endfunction

    // A half-width product always fits DATA_W bits; widen to PROD_W.
    function automatic logic [PROD_W-1:0] mul_half(
        input logic [HALF_W-1:0] a,
        input logic [HALF_W-1:0] b
    );
        logic [DATA_W-1:0] ax;
        logic [DATA_W-1:0] bx;
        logic [DATA_W-1:0] p;
        ax = {{HALF_W{a[HALF_W-1]}}, a};
        bx = {{HALF_W{b[HALF_W-1]}}, b};
        p  = ax * bx;
        return {{DATA_W{p[DATA_W-1]}}, p};
    endfunction

    // S1
    logic                         v1_q, v1_d;
    logic                         first1_q, first1_d;
    logic                         last1_q, last1_d;
    logic [ACC_W-1:0]             seed1_q, seed1_d;
    logic [NPROD-1:0][PROD_W-1:0] prod_q, prod_d;
    // S2
    logic                         v2_q, v2_d;
    logic                         first2_q, first2_d;
    logic                         last2_q, last2_d;
    logic [ACC_W-1:0]             seed2_q, seed2_d;
    logic [SUM_W-1:0]             dot_q, dot_d;
    // S3
    logic [ACC_W-1:0]             acc_q, acc_d;
    logic                         sat_q, sat_d;
    logic                         out_valid_q, out_valid_d;
    logic [ACC_W-1:0]             psum_out_q, psum_out_d;
    logic                         out_sat_q, out_sat_d;

    logic [ACC_W-1:0]             base;
    logic [RAW_W-1:0]             raw;
    logic [RAW_W-ACC_W:0]         raw_hi;
    logic                         clamped;
    logic [ACC_W-1:0]             acc_next;

    always_comb begin
        // S1: per-lane products
        v1_d     = in_valid;
        first1_d = in_first;
        last1_d  = in_last;
        seed1_d  = in_valid ? partial_sum_in : seed1_q;
        prod_d   = prod_q;
        if (in_valid) begin
            for (int i = 0; i < LANES; i++) begin
                if (half_mode) begin
                    prod_d[2*i] = mul_half(
                        a_vec[i*DATA_W +: HALF_W],
                        b_vec[i*DATA_W +: HALF_W]);
                    prod_d[2*i+1] = mul_half(
                        a_vec[i*DATA_W+HALF_W +: HALF_W],
                        b_vec[i*DATA_W+HALF_W +: HALF_W]);
                end else begin
                    prod_d[2*i] = mul_full(
                        a_vec[i*DATA_W +: DATA_W],
                        b_vec[i*DATA_W +: DATA_W]);
                    prod_d[2*i+1] = '0;
                end
            end
        end

        // S2: full-precision reduction
        v2_d     = v1_q;
        first2_d = first1_q;
        last2_d  = last1_q;
        seed2_d  = seed1_q;
        dot_d    = '0;
        for (int j = 0; j < NPROD; j++) begin
            dot_d = dot_d + {{(SUM_W-PROD_W){prod_q[j][PROD_W-1]}},
                             prod_q[j]};
        end

        // S3: accumulate with saturation
        base = first2_q ? seed2_q : acc_q;
        raw  = {{(RAW_W-ACC_W){base[ACC_W-1]}}, base}
             + {{(RAW_W-SUM_W){dot_q[SUM_W-1]}}, dot_q};
        // Representable iff every bit above the ACC_W sign bit matches it.
        raw_hi  = raw[RAW_W-1:ACC_W-1];
        clamped = !((&raw_hi) || !(|raw_hi));
        if (!clamped) begin
            acc_next = raw[ACC_W-1:0];
        end else if (raw[RAW_W-1]) begin
            acc_next = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            acc_next = {1'b0, {(ACC_W-1){1'b1}}};
        end

        acc_d       = acc_q;
        sat_d       = sat_q;
        out_valid_d = 1'b0;
        psum_out_d  = psum_out_q;
        out_sat_d   = out_sat_q;
        if (v2_q) begin
            acc_d = acc_next;
            sat_d = (first2_q ? 1'b0 : sat_q) | clamped;
            if (last2_q) begin
                out_valid_d = 1'b1;
                psum_out_d  = acc_next;
                out_sat_d   = sat_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            first1_q    <= 1'b0;
            last1_q     <= 1'b0;
            seed1_q     <= '0;
            prod_q      <= '0;
            v2_q        <= 1'b0;
            first2_q    <= 1'b0;
            last2_q     <= 1'b0;
            seed2_q     <= '0;
            dot_q       <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            psum_out_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            first1_q    <= first1_d;
            last1_q     <= last1_d;
            seed1_q     <= seed1_d;
            prod_q      <= prod_d;
            v2_q        <= v2_d;
            first2_q    <= first2_d;
            last2_q     <= last2_d;
            seed2_q     <= seed2_d;
            dot_q       <= dot_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            psum_out_q  <= psum_out_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign partial_sum_out = psum_out_q;
    assign out_sat         = out_sat_q;
endmodule

// File: tb/tb_mac_vec_pipe.sv
// tb_mac_vec_pipe: directed self-checking bench for mac_vec_pipe.
// Beats are uniform across lanes; results are collected per negedge.
module tb_mac_vec_pipe;
    localparam int LANES  = 33;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_first;
    logic                    in_last;
    logic                    half_mode;
    logic [LANES*DATA_W-1:0] a_vec;
    logic [LANES*DATA_W-1:0] b_vec;
    logic [ACC_W-1:0]        partial_sum_in;
    logic                    out_valid;
    logic [ACC_W-1:0]        partial_sum_out;
    logic                    out_sat;

    always #5 clk = ~clk;

    mac_vec_pipe #(
        .LANES (LANES),
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_first       (in_first),
        .in_last        (in_last),
        .half_mode      (half_mode),
        .a_vec          (a_vec),
        .b_vec          (b_vec),
        .partial_sum_in (partial_sum_in),
        .out_valid      (out_valid),
        .partial_sum_out(partial_sum_out),
        .out_sat        (out_sat)
    );

    typedef struct {
        int               cyc;
        logic [ACC_W-1:0] ps;
        logic             sat;
    } res_t;

    res_t rq[$];
    int   cyc      = 0;
    int   last_cyc = 0;
    int   checks   = 0;
    int   failures = 0;

    task automatic drive(input logic v, input logic f, input logic l,
                         input logic h, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input int seed);
        res_t r;
        @(negedge clk);
        cyc++;
        if (out_valid === 1'b1) begin
            r.cyc = cyc;
            r.ps  = partial_sum_out;
            r.sat = out_sat;
            rq.push_back(r);
        end
        in_valid       = v;
        in_first       = f;
        in_last        = l;
        half_mode      = h;
        a_vec          = {LANES{a}};
        b_vec          = {LANES{b}};
        partial_sum_in = ACC_W'(seed);
        if (v && l) last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 0);
    endtask

    task automatic burst(input int n, input logic h,
                         input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input int seed);
        for (int k = 0; k < n; k++)
            drive(1'b1, k == 0, k == n - 1, h, a, b, seed);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(2);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (partial_sum_out !== '0) begin
            failures++;
            $display("FAIL reset_psum got=%0d exp=0", partial_sum_out);
        end
        checks++;
        if (out_sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_sat got=%b exp=0", out_sat);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_full_ones;
        rq.delete();
        burst(1, 1'b0, 8'h01, 8'h01, 0);
        idle(5);
        checks++;
        if (rq.size() !== 1) begin
            failures++;
            $display("FAIL ones_pulses got=%0d exp=1", rq.size());
        end else begin
            checks++;
            if (rq[0].cyc !== last_cyc + 3) begin
                failures++;
                $display("FAIL ones_latency got=%0d exp=3",
                         rq[0].cyc - last_cyc);
            end
            checks++;
            if (rq[0].ps !== ACC_W'(33)) begin
                failures++;
                $display("FAIL ones_psum got=%0d exp=33", rq[0].ps);
            end
            checks++;
            if (rq[0].sat !== 1'b0) begin
                failures++;
                $display("FAIL ones_sat got=%b exp=0", rq[0].sat);
            end
        end
    endtask

    task automatic test_single_min;
        rq.delete();
        burst(1, 1'b0, 8'h80, 8'h80, 0);
        idle(5);
        checks++;
        if (rq.size() !== 1) begin
            failures++;
            $display("FAIL min_pulses got=%0d exp=1", rq.size());
        end else begin
            checks++;
            if (rq[0].ps !== ACC_W'(540672) || rq[0].sat !== 1'b0) begin
                failures++;
                $display("FAIL min_single got=%0d/%b exp=540672/0",
                         rq[0].ps, rq[0].sat);
            end
        end
    endtask

    task automatic test_back_to_back;
        rq.delete();
        burst(15, 1'b0, 8'h80, 8'h80, 0);
        burst(16, 1'b0, 8'h80, 8'h80, 0);
        idle(5);
        checks++;
        if (rq.size() !== 2) begin
            failures++;
            $display("FAIL b2b_pulses got=%0d exp=2", rq.size());
        end else begin
            checks++;
            if (rq[0].ps !== ACC_W'(8110080) || rq[0].sat !== 1'b0) begin
                failures++;
                $display("FAIL b2b_15beat got=%0d/%b exp=8110080/0",
                         rq[0].ps, rq[0].sat);
            end
            checks++;
            if (rq[1].ps !== ACC_W'(8388607) || rq[1].sat !== 1'b1) begin
                failures++;
                $display("FAIL b2b_16beat_sat got=%0d/%b exp=8388607/1",
                         rq[1].ps, rq[1].sat);
            end
        end
    endtask

    task automatic test_half_mode;
        rq.delete();
        burst(1, 1'b1, 8'h8F, 8'h11, 10);
        idle(5);
        checks++;
        if (rq.size() !== 1) begin
            failures++;
            $display("FAIL half_pulses got=%0d exp=1", rq.size());
        end else begin
            checks++;
            if (rq[0].ps !== ACC_W'(-287) || rq[0].sat !== 1'b0) begin
                failures++;
                $display("FAIL half_psum got=%0d/%b exp=-287/0",
                         $signed(rq[0].ps), rq[0].sat);
            end
        end
    endtask

    task automatic test_chaining;
        rq.delete();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 100);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 0);
        idle(2);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 5);
        idle(5);
        checks++;
        if (rq.size() !== 3) begin
            failures++;
            $display("FAIL chain_pulses got=%0d exp=3", rq.size());
        end else begin
            checks++;
            if (rq[0].ps !== ACC_W'(199)) begin
                failures++;
                $display("FAIL chain_burst got=%0d exp=199", rq[0].ps);
            end
            checks++;
            if (rq[1].ps !== ACC_W'(232)) begin
                failures++;
                $display("FAIL chain_lone got=%0d exp=232", rq[1].ps);
            end
            checks++;
            if (rq[2].ps !== ACC_W'(38)) begin
                failures++;
                $display("FAIL chain_reseed got=%0d exp=38", rq[2].ps);
            end
        end
    endtask

    task automatic test_reset_mid;
        rq.delete();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(5);
        checks++;
        if (rq.size() !== 0) begin
            failures++;
            $display("FAIL rstmid_pulses got=%0d exp=0", rq.size());
        end
        checks++;
        if (partial_sum_out !== '0) begin
            failures++;
            $display("FAIL rstmid_psum got=%0d exp=0", partial_sum_out);
        end
        burst(1, 1'b0, 8'h01, 8'h01, 0);
        idle(5);
        checks++;
        if (rq.size() !== 1) begin
            failures++;
            $display("FAIL rstmid_after_pulses got=%0d exp=1", rq.size());
        end else begin
            checks++;
            if (rq[0].ps !== ACC_W'(33)) begin
                failures++;
                $display("FAIL rstmid_after got=%0d exp=33", rq[0].ps);
            end
        end
    endtask

    task automatic test_neg_clamp;
        rq.delete();
        burst(1, 1'b0, 8'h80, 8'h7F, -8388000);
        burst(1, 1'b0, 8'h01, 8'h01, 0);
        idle(5);
        checks++;
        if (rq.size() !== 2) begin
            failures++;
            $display("FAIL neg_pulses got=%0d exp=2", rq.size());
        end else begin
            checks++;
            if (rq[0].ps !== ACC_W'(-8388608) || rq[0].sat !== 1'b1) begin
                failures++;
                $display("FAIL neg_clamp got=%0d/%b exp=-8388608/1",
                         $signed(rq[0].ps), rq[0].sat);
            end
            checks++;
            if (rq[1].ps !== ACC_W'(33) || rq[1].sat !== 1'b0) begin
                failures++;
                $display("FAIL neg_sat_clear got=%0d/%b exp=33/0",
                         rq[1].ps, rq[1].sat);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_first       = 1'b0;
        in_last        = 1'b0;
        half_mode      = 1'b0;
        a_vec          = '0;
        b_vec          = '0;
        partial_sum_in = '0;
        test_reset();
        test_full_ones();
        test_single_min();
        test_back_to_back();
        test_half_mode();
        test_chaining();
        test_reset_mid();
        test_neg_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
